// File: rtl/reg_file_pkg.sv
// Shared widths and types for the 32x32 register file.
// Included first so the read-port sub-module and the top agree on geometry.
package reg_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: zero-latency array mux, no backpressure.
// REG_FILE_BYPASS_EN adds write-through forwarding of the pending write data.
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  logic [DATA_W-1:0] mem_i [0:DEPTH-1],
  input  logic [ADDR_W-1:0] raddr_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic              byp_vld_i,
  input  logic [ADDR_W-1:0] byp_addr_i,
  input  logic [DATA_W-1:0] byp_dat_i,
`endif
  output logic [DATA_W-1:0] dout_o
);

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    dout_o = mem_i[raddr_i];
    if (byp_vld_i && (byp_addr_i == raddr_i)) begin
      dout_o = byp_dat_i;
    end
  end
`else
  assign dout_o = mem_i[raddr_i];
`endif

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port committed at posedge clk.
// Optional REG_FILE_BYPASS_EN forwards an in-flight write to matching read ports; no backpressure.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] dout1
);

  reg_data_t mem [0:DEPTH-1];

  logic      wr_en;
  reg_addr_t wr_idx;

  // The address MSB marks an out-of-range target; such writes are dropped.
  assign wr_en  = we && !waddr[ADDR_W];
  assign wr_idx = waddr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic byp_vld;

  // Gated by reset so both ports still read zero while rst_n is low.
  assign byp_vld = wr_en && rst_n;

  reg_file_rd_port u_rd_port0 (
    .mem_i      (mem),
    .raddr_i    (raddr0),
    .byp_vld_i  (byp_vld),
    .byp_addr_i (wr_idx),
    .byp_dat_i  (din),
    .dout_o     (dout0)
  );

  reg_file_rd_port u_rd_port1 (
    .mem_i      (mem),
    .raddr_i    (raddr1),
    .byp_vld_i  (byp_vld),
    .byp_addr_i (wr_idx),
    .byp_dat_i  (din),
    .dout_o     (dout1)
  );
`else
  reg_file_rd_port u_rd_port0 (
    .mem_i   (mem),
    .raddr_i (raddr0),
    .dout_o  (dout0)
  );

  reg_file_rd_port u_rd_port1 (
    .mem_i   (mem),
    .raddr_i (raddr1),
    .dout_o  (dout1)
  );
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, fill, out-of-range drop, hold, dual read,
// same-cycle read/write (with or without REG_FILE_BYPASS_EN) and reset overriding a write.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr0;
  logic [4:0]  raddr1;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] din;
  logic [31:0] dout0;
  logic [31:0] dout1;

  logic [31:0] exp_mem [0:31];
  int          errors;
  int          checks;

  reg_file dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .we     (we),
    .waddr  (waddr),
    .din    (din),
    .dout0  (dout0),
    .dout1  (dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task test_reset;
    rst_n = 1'b1; we = 1'b0; waddr = '0; din = '0; raddr0 = 5'd4; raddr1 = 5'd5;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    checks++;
    if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout0 got=%h exp=%h", dout0, 32'h0); end
    checks++;
    if (dout1 !== 32'h0) begin errors++; $display("FAIL reset_dout1 got=%h exp=%h", dout1, 32'h0); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.mem[i] !== 32'h0) begin
        errors++; $display("FAIL reset_mem[%0d] got=%h exp=%h", i, dut.mem[i], 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_write_all;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 6'(i); din = 32'(i + 1);
      exp_mem[i] = 32'(i + 1);
    end
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL fill_mem[%0d] got=%h exp=%h", i, dut.mem[i], exp_mem[i]);
      end
    end
    raddr0 = 5'd14; raddr1 = 5'd15;
    #1;
    checks++;
    if (dout0 !== 32'h0000000F) begin errors++; $display("FAIL fill_dout0 got=%h exp=%h", dout0, 32'hF); end
    checks++;
    if (dout1 !== 32'h00000010) begin errors++; $display("FAIL fill_dout1 got=%h exp=%h", dout1, 32'h10); end
  endtask

  task test_out_of_range;
    @(negedge clk);
    we = 1'b1; waddr = 6'd32; din = 32'hDEADBEEF; raddr0 = 5'd0;
    #1;
    checks++;
    if (dout0 !== 32'h1) begin errors++; $display("FAIL oor32_dout0 got=%h exp=%h", dout0, 32'h1); end
    @(negedge clk);
    waddr = 6'd63; raddr0 = 5'd31;
    #1;
    checks++;
    if (dout0 !== 32'd32) begin errors++; $display("FAIL oor63_dout0 got=%h exp=%h", dout0, 32'd32); end
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL oor_mem[%0d] got=%h exp=%h", i, dut.mem[i], exp_mem[i]);
      end
    end
  endtask

  task test_hold;
    @(negedge clk);
    we = 1'b0; waddr = 6'd5; din = 32'h11111111; raddr0 = 5'd0;
    #1;
    checks++;
    if (dout0 !== 32'h1) begin errors++; $display("FAIL hold_rd0 got=%h exp=%h", dout0, 32'h1); end
    raddr0 = 5'd31;
    #1;
    checks++;
    if (dout0 !== 32'd32) begin errors++; $display("FAIL hold_rd31 got=%h exp=%h", dout0, 32'd32); end
    raddr0 = 5'd14;
    #1;
    checks++;
    if (dout0 !== 32'd15) begin errors++; $display("FAIL hold_rd14 got=%h exp=%h", dout0, 32'd15); end
    @(negedge clk);
    din = 32'h22222222;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL hold_mem[%0d] got=%h exp=%h", i, dut.mem[i], exp_mem[i]);
      end
    end
  endtask

  task test_same_addr;
    @(negedge clk);
    we = 1'b1; waddr = 6'd7; din = 32'hA5A5A5A5;
    exp_mem[7] = 32'hA5A5A5A5;
    @(negedge clk);
    we = 1'b0; raddr0 = 5'd7; raddr1 = 5'd7;
    #1;
    checks++;
    if (dout0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL dual_dout0 got=%h exp=%h", dout0, 32'hA5A5A5A5); end
    checks++;
    if (dout1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL dual_dout1 got=%h exp=%h", dout1, 32'hA5A5A5A5); end
  endtask

  task test_same_cycle;
    logic [31:0] pre_exp;
`ifdef REG_FILE_BYPASS_EN
    pre_exp = 32'h12345678;
`else
    pre_exp = 32'h00000004;
`endif
    @(negedge clk);
    we = 1'b1; waddr = 6'd3; din = 32'h12345678; raddr0 = 5'd3; raddr1 = 5'd7;
    #1;
    checks++;
    if (dout0 !== pre_exp) begin errors++; $display("FAIL samecyc_pre_dout0 got=%h exp=%h", dout0, pre_exp); end
    checks++;
    if (dout1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL samecyc_pre_dout1 got=%h exp=%h", dout1, 32'hA5A5A5A5); end
    @(posedge clk);
    #1;
    exp_mem[3] = 32'h12345678;
    checks++;
    if (dout0 !== 32'h12345678) begin errors++; $display("FAIL samecyc_post_dout0 got=%h exp=%h", dout0, 32'h12345678); end
    @(negedge clk);
    we = 1'b0;
    #1;
    checks++;
    if (dut.mem[3] !== 32'h12345678) begin errors++; $display("FAIL samecyc_mem3 got=%h exp=%h", dut.mem[3], 32'h12345678); end
  endtask

  task test_reset_mid_write;
    @(negedge clk);
    we = 1'b1; waddr = 6'd3; din = 32'hCAFEF00D; raddr0 = 5'd3; raddr1 = 5'd7;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout0 !== 32'h0) begin errors++; $display("FAIL rstmid_async_dout0 got=%h exp=%h", dout0, 32'h0); end
    checks++;
    if (dout1 !== 32'h0) begin errors++; $display("FAIL rstmid_async_dout1 got=%h exp=%h", dout1, 32'h0); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL rstmid_mem[%0d] got=%h exp=%h", i, dut.mem[i], exp_mem[i]);
      end
    end
    checks++;
    if (dout0 !== 32'h0) begin errors++; $display("FAIL rstmid_edge_dout0 got=%h exp=%h", dout0, 32'h0); end
    @(negedge clk);
    #2 rst_n = 1'b1; din = 32'h0BADF00D;
    #1;
    checks++;
    if (dut.mem[3] !== 32'h0) begin errors++; $display("FAIL rstrel_early_mem3 got=%h exp=%h", dut.mem[3], 32'h0); end
    @(posedge clk);
    #1;
    checks++;
    if (dut.mem[3] !== 32'h0BADF00D) begin errors++; $display("FAIL rstrel_mem3 got=%h exp=%h", dut.mem[3], 32'h0BADF00D); end
    @(negedge clk);
    we = 1'b0;
    #1;
    checks++;
    if (dout0 !== 32'h0BADF00D) begin errors++; $display("FAIL rstrel_dout0 got=%h exp=%h", dout0, 32'h0BADF00D); end
    checks++;
    if (dout1 !== 32'h0) begin errors++; $display("FAIL rstrel_dout1 got=%h exp=%h", dout1, 32'h0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_all();
    test_out_of_range();
    test_hold();
    test_same_addr();
    test_same_cycle();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
